// File: rtl/prbs5_checker_if.sv
// Receive-side bus of the PRBS5 checker: serial data in, lock/error status out.
// The optional bit_cnt signal exists only when PRBS5_CHK_BITCNT_EN is defined.
interface prbs5_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
`ifdef PRBS5_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  modport master (
    output bit_in, bit_valid, clear,
    input  locked, err_pulse, err_count
`ifdef PRBS5_CHK_BITCNT_EN
    , input bit_cnt
`endif
  );

  modport slave (
    input  bit_in, bit_valid, clear,
    output locked, err_pulse, err_count
`ifdef PRBS5_CHK_BITCNT_EN
    , output bit_cnt
`endif
  );
endinterface

// File: rtl/prbs5_checker.sv
// PRBS5 (x^5+x^2+1) serial checker: self-synchronises in SEARCH, then flywheels
// the local predictor in LOCKED and counts bit errors with windowed loss-of-lock.
// Optional feature macro: PRBS5_CHK_BITCNT_EN adds the 32-bit bit_cnt counter.
module prbs5_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned WIN      = 31,
  parameter int unsigned ERR_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  prbs5_checker_if.slave bus
);

  localparam int unsigned WW = $clog2(WIN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [4:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       run_q, run_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [WW-1:0]    win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
`ifdef PRBS5_CHK_BITCNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  logic             pred;
  logic             mismatch;
  logic [4:0]       hist_rx;
  logic [7:0]       run_inc;
  logic [WW-1:0]    win_cnt_inc;
  logic [WW-1:0]    win_err_inc;

  // Next-state logic: search/lock FSM, predictor history, window and error counters
  always_comb begin
    pred        = hist_q[1] ^ hist_q[4];
    mismatch    = bus.bit_in ^ pred;
    hist_rx     = {hist_q[3:0], bus.bit_in};
    run_inc     = run_q + 8'd1;
    win_cnt_inc = win_cnt_q + WW'(1);
    win_err_inc = win_err_q + WW'(1);

    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
`ifdef PRBS5_CHK_BITCNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif

    if (bus.bit_valid) begin
      case (state_q)
        SEARCH: begin
          // Received bits train the history; the all-zero pattern never counts as a match
          hist_d = hist_rx;
          if (fill_q != 3'd5) begin
            fill_d = fill_q + 3'd1;
          end else if (!mismatch && (hist_rx != '0)) begin
            run_d = run_inc;
            if (run_inc == 8'(LOCK_CNT)) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the predictor feeds itself so received errors cannot corrupt it
          hist_d      = {hist_q[3:0], pred};
          err_pulse_d = mismatch;
          if (mismatch && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
`ifdef PRBS5_CHK_BITCNT_EN
          bit_cnt_d = bit_cnt_q + 32'd1;
`endif
          // Loss of lock is tested before window rollover so it wins on the closing bit
          if (mismatch && (win_err_inc == WW'(LOSS_THR))) begin
            state_d   = SEARCH;
            locked_d  = 1'b0;
            fill_d    = '0;
            run_d     = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_inc == WW'(WIN)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            if (mismatch) begin
              win_err_d = win_err_inc;
            end
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    if (bus.clear) begin
      err_count_d = '0;
`ifdef PRBS5_CHK_BITCNT_EN
      bit_cnt_d   = '0;
`endif
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
`ifdef PRBS5_CHK_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
`ifdef PRBS5_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
`ifdef PRBS5_CHK_BITCNT_EN
  assign bus.bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: default instance plus a small-counter
// instance (ERR_W=4, LOSS_THR=WIN=31) for saturation.
module tb_prbs5_checker;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [4:0] ga;
  logic [4:0] gb;

  always #5 clk = ~clk;

  prbs5_checker_if #(.ERR_W(16)) ia ();
  prbs5_checker_if #(.ERR_W(4))  ib ();

  prbs5_checker #(.LOCK_CNT(8), .LOSS_THR(4), .WIN(31), .ERR_W(16)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  prbs5_checker #(.LOCK_CNT(8), .LOSS_THR(31), .WIN(31), .ERR_W(4)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic gen_a(output logic b);
    b  = ga[1] ^ ga[4];
    ga = {ga[3:0], b};
  endtask

  task automatic gen_b(output logic b);
    b  = gb[1] ^ gb[4];
    gb = {gb[3:0], b};
  endtask

  task automatic step_a(input logic b, input logic v, input logic clr);
    ia.bit_in = b; ia.bit_valid = v; ia.clear = clr;
    @(posedge clk); #1;
    ia.bit_valid = 1'b0; ia.clear = 1'b0;
  endtask

  task automatic step_b(input logic b, input logic v, input logic clr);
    ib.bit_in = b; ib.bit_valid = v; ib.clear = clr;
    @(posedge clk); #1;
    ib.bit_valid = 1'b0; ib.clear = 1'b0;
  endtask

  task automatic send_a(input logic flip);
    logic b;
    gen_a(b);
    step_a(b ^ flip, 1'b1, 1'b0);
  endtask

  task automatic send_b(input logic flip);
    logic b;
    gen_b(b);
    step_b(b ^ flip, 1'b1, 1'b0);
  endtask

  task automatic lock_a(input string tag);
    for (int i = 1; i <= 13; i++) begin
      send_a(1'b0);
      if (i == 12) chk({tag, "_pre_lock"}, ia.locked, 0);
    end
    chk({tag, "_lock_at_13"}, ia.locked, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int   npulse;
    int   vc;
    logic seen;
    logic b;
    logic v;

    ia.bit_in = 1'b0; ia.bit_valid = 1'b0; ia.clear = 1'b0;
    ib.bit_in = 1'b0; ib.bit_valid = 1'b0; ib.clear = 1'b0;
    ga = 5'b00001; gb = 5'b00001;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked",    ia.locked, 0);
    chk("rst_err_pulse", ia.err_pulse, 0);
    chk("rst_err_count", ia.err_count, 0);
    chk("rst_b_locked",  ib.locked, 0);
    rst = 1'b1;

    // clean stream: lock on bit 13, no errors through bit 200
    lock_a("clean");
    repeat (187) send_a(1'b0);
    chk("clean200_locked", ia.locked, 1);
    chk("clean200_errs",   ia.err_count, 0);
`ifdef PRBS5_CHK_BITCNT_EN
    chk("clean200_bitcnt", ia.bit_cnt, 187);
`endif

    // single flipped bit
    send_a(1'b1);
    chk("flip1_pulse",  ia.err_pulse, 1);
    chk("flip1_count",  ia.err_count, 1);
    chk("flip1_locked", ia.locked, 1);
    npulse = 0;
    repeat (62) begin
      send_a(1'b0);
      npulse += int'(ia.err_pulse);
    end
    chk("flip1_no_more_pulses", npulse, 0);
    chk("flip1_count_hold",     ia.err_count, 1);

    // clear, then 4 errors in one window drop lock
    step_a(1'b0, 1'b0, 1'b1);
    chk("clear_count", ia.err_count, 0);
`ifdef PRBS5_CHK_BITCNT_EN
    chk("clear_bitcnt", ia.bit_cnt, 0);
`endif
    for (int i = 1; i <= 4; i++) begin
      send_a(1'b1);
      if (i == 3) chk("flip4_third_locked", ia.locked, 1);
    end
    chk("flip4_locked", ia.locked, 0);
    chk("flip4_pulse",  ia.err_pulse, 1);
    chk("flip4_count",  ia.err_count, 4);
    lock_a("relock1");

    // clear coincident with an error; 4th error on the window-closing bit still drops lock
    gen_a(b);
    step_a(~b, 1'b1, 1'b1);
    chk("clr_err_pulse", ia.err_pulse, 1);
    chk("clr_err_count", ia.err_count, 0);
    repeat (27) send_a(1'b0);
    send_a(1'b1);
    send_a(1'b1);
    chk("winend_pre_locked", ia.locked, 1);
    send_a(1'b1);
    chk("winend_loss", ia.locked, 0);
    chk("winend_count", ia.err_count, 3);
    lock_a("relock2");

    // 3 errors closing one window plus 1 opening the next: lock kept
    repeat (28) send_a(1'b0);
    repeat (3) send_a(1'b1);
    chk("straddle_mid_locked", ia.locked, 1);
    send_a(1'b1);
    chk("straddle_locked", ia.locked, 1);
    chk("straddle_count",  ia.err_count, 7);
    chk("straddle_pulse",  ia.err_pulse, 1);

    // asynchronous reset while locked
    rst = 1'b0;
    #1;
    chk("arst_locked_imm", ia.locked, 0);
    @(posedge clk); #1;
    chk("arst_locked",    ia.locked, 0);
    chk("arst_err_pulse", ia.err_pulse, 0);
    chk("arst_err_count", ia.err_count, 0);
    rst = 1'b1;

    // all-zero and all-ones streams never lock
    seen = 1'b0;
    repeat (100) begin
      step_a(1'b0, 1'b1, 1'b0);
      seen |= ia.locked;
    end
    chk("zeros_never_lock", seen, 0);
    pulse_reset();
    seen = 1'b0;
    repeat (100) begin
      step_a(1'b1, 1'b1, 1'b0);
      seen |= ia.locked;
    end
    chk("ones_never_lock", seen, 0);
    pulse_reset();

    // ~30% bit_valid duty: lock still on valid bit 13
    ga = 5'b00001;
    vc = 0;
    for (int cyc = 0; cyc < 2000 && vc < 13; cyc++) begin
      v = ($urandom_range(0, 9) < 3);
      if (v) begin
        gen_a(b);
        step_a(b, 1'b1, 1'b0);
        vc++;
        if (vc == 12) chk("rnd_pre_lock", ia.locked, 0);
        if (vc == 13) chk("rnd_lock_at_13", ia.locked, 1);
      end else begin
        step_a(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    chk("rnd_bound", vc, 13);

    // small instance: error count saturates at 15, clear returns to 0
    for (int i = 1; i <= 13; i++) send_b(1'b0);
    chk("b_lock", ib.locked, 1);
    for (int i = 1; i <= 20; i++) begin
      send_b(1'b1);
      if (i == 14) chk("b_count14", ib.err_count, 14);
      if (i == 15) chk("b_count15", ib.err_count, 15);
    end
    chk("b_sat_count",  ib.err_count, 15);
    chk("b_sat_locked", ib.locked, 1);
    chk("b_sat_pulse",  ib.err_pulse, 1);
    step_b(1'b0, 1'b0, 1'b1);
    chk("b_clear", ib.err_count, 0);
`ifdef PRBS5_CHK_BITCNT_EN
    chk("b_clear_bitcnt", ib.bit_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
